// File: rtl/mid_3x3_dpc_if.sv
// Window-in / result-out bundle for the 3x3 median / defect-correction filter.
// The filter itself uses the slave view; the upstream/downstream side uses master.
interface mid_3x3_dpc_if #(
  parameter int DW    = 8,
  parameter int CNT_W = 20
);
  logic              i_valid;
  logic              i_sof;
  logic [9*DW-1:0]   i_win;
  logic [1:0]        i_mode;
  logic [DW-1:0]     i_thr;
  logic              o_valid;
  logic              o_sof;
  logic [DW-1:0]     o_data;
  logic              o_defect;
  logic [CNT_W-1:0]  o_defect_cnt;

  modport master (
    output i_valid, i_sof, i_win, i_mode, i_thr,
    input  o_valid, o_sof, o_data, o_defect, o_defect_cnt
  );

  modport slave (
    input  i_valid, i_sof, i_win, i_mode, i_thr,
    output o_valid, o_sof, o_data, o_defect, o_defect_cnt
  );
endinterface

// File: rtl/mid_3x3_dpc.sv
// Stall-free 3x3 window filter: median / min / max / defect-corrected centre,
// with a per-frame saturating count of replaced pixels. Window sampled at edge N is output after edge N+4.
module mid_3x3_dpc #(
  parameter int DW    = 8,
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             reset_n,
  mid_3x3_dpc_if.slave     bus
);

  localparam logic [1:0] MODE_MED = 2'b00;
  localparam logic [1:0] MODE_MIN = 2'b01;
  localparam logic [1:0] MODE_MAX = 2'b10;

  typedef struct packed {
    logic [DW-1:0] hi;
    logic [DW-1:0] mid;
    logic [DW-1:0] lo;
  } trio_t;

  // Ties resolve as "not greater", so equal inputs give the same value whichever wins.
  function automatic logic [DW-1:0] max2(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [DW-1:0] min2(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a > b) ? b : a;
  endfunction

  function automatic logic [DW-1:0] max3(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                         input logic [DW-1:0] c);
    return max2(max2(a, b), c);
  endfunction

  function automatic logic [DW-1:0] min3(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                         input logic [DW-1:0] c);
    return min2(min2(a, b), c);
  endfunction

  function automatic logic [DW-1:0] mid3(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                         input logic [DW-1:0] c);
    return max2(min2(a, b), min2(max2(a, b), c));
  endfunction

  // Two guard bits keep the subtraction from wrapping; the magnitude always fits DW+1 bits.
  function automatic logic [DW:0] abs_diff(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic signed [DW+1:0] d;
    d = $signed({2'b00, a}) - $signed({2'b00, b});
    return (d < 0) ? (DW+1)'(-d) : (DW+1)'(d);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Stage 0: input capture
  logic             vld_p0, sof_p0;
  logic [9*DW-1:0]  win_p0;
  logic [1:0]       mode_p0;
  logic [DW-1:0]    thr_p0;

  always_ff @(posedge clk) begin
    win_p0  <= bus.i_win;
    mode_p0 <= bus.i_mode;
    thr_p0  <= bus.i_thr;
  end

  // Stage 1: per-row sort
  trio_t            row_c [3];
  trio_t            row_p1 [3];
  logic [DW-1:0]    centre_p1;
  logic [1:0]       mode_p1;
  logic [DW-1:0]    thr_p1;
  logic             vld_p1, sof_p1;

  for (genvar r = 0; r < 3; r++) begin : g_row
    logic [DW-1:0] a, b, c;
    assign a = win_p0[(8-3*r)*DW +: DW];
    assign b = win_p0[(7-3*r)*DW +: DW];
    assign c = win_p0[(6-3*r)*DW +: DW];
    assign row_c[r].hi  = max3(a, b, c);
    assign row_c[r].mid = mid3(a, b, c);
    assign row_c[r].lo  = min3(a, b, c);
  end

  always_ff @(posedge clk) begin
    row_p1    <= row_c;
    centre_p1 <= win_p0[4*DW +: DW];
    mode_p1   <= mode_p0;
    thr_p1    <= thr_p0;
  end

  // Stage 2: column sorts of the row results, plus global min/max
  logic [DW-1:0]    min_of_max_p2, mid_of_mid_p2, max_of_min_p2;
  logic [DW-1:0]    gmin_p2, gmax_p2, centre_p2, thr_p2;
  logic [1:0]       mode_p2;
  logic             vld_p2, sof_p2;

  always_ff @(posedge clk) begin
    min_of_max_p2 <= min3(row_p1[0].hi,  row_p1[1].hi,  row_p1[2].hi);
    mid_of_mid_p2 <= mid3(row_p1[0].mid, row_p1[1].mid, row_p1[2].mid);
    max_of_min_p2 <= max3(row_p1[0].lo,  row_p1[1].lo,  row_p1[2].lo);
    gmin_p2       <= min3(row_p1[0].lo,  row_p1[1].lo,  row_p1[2].lo);
    gmax_p2       <= max3(row_p1[0].hi,  row_p1[1].hi,  row_p1[2].hi);
    centre_p2     <= centre_p1;
    thr_p2        <= thr_p1;
    mode_p2       <= mode_p1;
  end

  // Stage 3: median, centre deviation and defect decision
  logic [DW-1:0]    med_c;
  logic [DW:0]      diff_c;
  logic [DW-1:0]    med_p3, centre_p3, gmin_p3, gmax_p3;
  logic [1:0]       mode_p3;
  logic             defect_p3, vld_p3, sof_p3;

  assign med_c  = mid3(min_of_max_p2, mid_of_mid_p2, max_of_min_p2);
  assign diff_c = abs_diff(centre_p2, med_c);

  always_ff @(posedge clk) begin
    med_p3    <= med_c;
    centre_p3 <= centre_p2;
    gmin_p3   <= gmin_p2;
    gmax_p3   <= gmax_p2;
    mode_p3   <= mode_p2;
    defect_p3 <= diff_c > {1'b0, thr_p2};
  end

  // Valid/sof travel beside the data; sof is masked by valid on entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p0 <= 1'b0;  sof_p0 <= 1'b0;
      vld_p1 <= 1'b0;  sof_p1 <= 1'b0;
      vld_p2 <= 1'b0;  sof_p2 <= 1'b0;
      vld_p3 <= 1'b0;  sof_p3 <= 1'b0;
    end else begin
      vld_p0 <= bus.i_valid;
      sof_p0 <= bus.i_valid & bus.i_sof;
      vld_p1 <= vld_p0;  sof_p1 <= sof_p0;
      vld_p2 <= vld_p1;  sof_p2 <= sof_p1;
      vld_p3 <= vld_p2;  sof_p3 <= sof_p2;
    end
  end

  // Stage 4: result select, output register and frame defect counter
  logic [DW-1:0]    res_c;
  logic             hit_c;
  logic             vld_p4, sof_p4, defect_p4;
  logic [DW-1:0]    data_p4;
  logic [CNT_W-1:0] cnt_p4;

  assign hit_c = (mode_p3 == 2'b11) && defect_p3;

  always_comb begin
    res_c = med_p3;
    case (mode_p3)
      MODE_MED: res_c = med_p3;
      MODE_MIN: res_c = gmin_p3;
      MODE_MAX: res_c = gmax_p3;
      default:  res_c = defect_p3 ? med_p3 : centre_p3;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p4    <= 1'b0;
      sof_p4    <= 1'b0;
      defect_p4 <= 1'b0;
      data_p4   <= '0;
      cnt_p4    <= '0;
    end else begin
      vld_p4    <= vld_p3;
      sof_p4    <= sof_p3;
      defect_p4 <= vld_p3 & hit_c;
      if (vld_p3) begin
        data_p4 <= res_c;
        if (sof_p3)
          cnt_p4 <= {{(CNT_W-1){1'b0}}, hit_c};
        else if (hit_c)
          cnt_p4 <= sat_inc(cnt_p4);
      end
    end
  end

  assign bus.o_valid      = vld_p4;
  assign bus.o_sof        = sof_p4;
  assign bus.o_data       = data_p4;
  assign bus.o_defect     = defect_p4;
  assign bus.o_defect_cnt = cnt_p4;

endmodule
